// File: rtl/parity4_pkg.sv
// Shared constants and the parity helper for the 4-input parity checker.
package parity4_pkg;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;
  localparam int DEF_CNT_W   = 16;
  localparam int SYNC_STAGES = 2;

  function automatic logic parity4(input logic [3:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/parity4_sync2.sv
// Generic 1-bit multi-flop synchronizer (SYNC_STAGES deep) with async active-low reset.
module parity4_sync2
  import parity4_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], din};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/parity4_checker.sv
// Registered 4-input parity checker driving a status LED, with edge flag and saturating count.
// Optional input synchronizers enabled by defining PARITY4_SYNC_EN.
module parity4_checker
  import parity4_pkg::*;
#(
  parameter int ODD   = PARITY_EVEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             clr,
  output logic             led,
  output logic             led_edge,
  output logic [CNT_W-1:0] odd_cnt
);

  localparam logic             ODD_BIT = ODD[0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0] raw_bits;
  logic [3:0] bits;
  logic       p;

  assign raw_bits = {d, c, b, a};

`ifdef PARITY4_SYNC_EN
  for (genvar i = 0; i < 4; i++) begin : g_sync
    parity4_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (raw_bits[i]),
      .q     (bits[i])
    );
  end
`else
  assign bits = raw_bits;
`endif

  assign p = parity4(bits, ODD_BIT);

  // led_edge compares the value led is about to take with its current value, so it
  // always equals led ^ (led one cycle earlier) without a separate led_prev flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led      <= 1'b0;
      led_edge <= 1'b0;
      odd_cnt  <= '0;
    end else begin
      led      <= p;
      led_edge <= p ^ led;
      if (clr) begin
        odd_cnt <= '0;
      end else if (p && (odd_cnt != CNT_MAX)) begin
        odd_cnt <= odd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity4_checker.sv
// Directed self-checking bench for parity4_checker (even, odd and 3-bit-counter instances).
`timescale 1ns/1ps
module tb_parity4_checker;

`ifdef PARITY4_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, a, b, c, d, clr;
  logic led0, edge0, led1, edge1, led3, edge3;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  parity4_checker u_even (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .led(led0), .led_edge(edge0), .odd_cnt(cnt0)
  );

  parity4_checker #(.ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .led(led1), .led_edge(edge1), .odd_cnt(cnt1)
  );

  parity4_checker #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .led(led3), .led_edge(edge3), .odd_cnt(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {d, c, b, a} = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    logic [3:0] hist [0:63];
    logic       exp_led, prev_led;
    int         trans, pulses;

    // Reset held with all inputs high
    rst_n = 1'b0; clr = 1'b0; drive(4'b1111);
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("rst_led0", led0, 0);  check("rst_edge0", edge0, 0); check("rst_cnt0", cnt0, 0);
      check("rst_led1", led1, 0);  check("rst_edge1", edge1, 0); check("rst_cnt1", cnt1, 0);
      check("rst_cnt3", cnt3, 0);
    end
    rst_n = 1'b1;
    tick(LAT);
    check("rel_led0", led0, 0); check("rel_edge0", edge0, 0); check("rel_cnt0", cnt0, 0);

    // Inputs 0000: even sense 0, odd sense 1
    drive(4'b0000);
    tick(LAT + 1);
    check("z_led0", led0, 0); check("z_edge0", edge0, 0); check("z_cnt0", cnt0, 0);
    check("z_led1", led1, 1); check("z_cnt3", cnt3, 0);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_cnt1", cnt1, 0);

    // Single-bit toggle a: 0 -> 1
    drive(4'b0001);
    tick(LAT - 1);
    check("a_led0_pre", led0, 0);
    tick(1);
    check("a_led0", led0, 1); check("a_edge0", edge0, 1); check("a_cnt0_1", cnt0, 1);
    check("a_cnt3_1", cnt3, 1); check("a_led1", led1, 0); check("a_edge1", edge1, 1);
    tick(1);
    check("a_led0_hold", led0, 1); check("a_edge0_off", edge0, 0); check("a_cnt0_2", cnt0, 2);
    tick(8);
    check("a_cnt0_10", cnt0, 10); check("sat_cnt3", cnt3, 7);

    // Odd sense with simultaneous b/c toggle
    drive(4'b0000);
    tick(LAT + 1);
    check("o_led1", led1, 1); check("o_edge1", edge1, 0);
    drive(4'b0110);
    for (int i = 0; i < LAT + 1; i++) begin
      tick(1);
      check("dbl_led1", led1, 1); check("dbl_edge1", edge1, 0);
      check("dbl_led0", led0, 0); check("dbl_edge0", edge0, 0);
    end

    // Clear takes priority over increment while saturated with p=1
    drive(4'b0001);
    tick(LAT);
    check("p1_led0", led0, 1); check("p1_cnt3_sat", cnt3, 7);
    clr = 1'b1; tick(1);
    check("clr_cnt3", cnt3, 0); check("clr_cnt0", cnt0, 0);
    clr = 1'b0; tick(1);
    check("post_clr_cnt3", cnt3, 1); check("post_clr_cnt0", cnt0, 1);

    // Asynchronous reset between edges
    tick(4);
    check("pre_rst_cnt0", cnt0, 5); check("pre_rst_led0", led0, 1);
    #1 rst_n = 1'b0;
    #2;
    check("async_led0", led0, 0); check("async_cnt0", cnt0, 0);
    check("async_cnt3", cnt3, 0); check("async_edge0", edge0, 0);
    drive(4'b0000);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_edge0", edge0, 0); check("post_rst_led0", led0, 0);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      check("post_rst_edge0_n", edge0, 0);
    end

    // Free-running toggles: a/10ns, b/20ns, c/25ns, d/15ns against a 10 ns clock period
    trans = 0; pulses = 0;
    for (int k = 0; k < 60; k++) begin
      hist[k] = {1'(((k * 10) / 15) % 2), 1'(((k * 10) / 25) % 2),
                 1'((k / 2) % 2), 1'(k % 2)};
      drive(hist[k]);
      tick(1);
      if (k >= LAT) begin
        exp_led  = ^hist[k - LAT + 1];
        prev_led = ^hist[k - LAT];
        check("free_led", led0, exp_led);
        check("free_edge", edge0, exp_led ^ prev_led);
        if (exp_led != prev_led) trans++;
        if (edge0) pulses++;
      end
    end
    check("edge_count", pulses, trans);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
